// File: rtl/servant_acc_pkg.sv
// Shared types and constants for the servant accelerator bridge.
// Holds the bridge FSM state set and the word/lane geometry.
package servant_acc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RMW_WAIT = 3'd2,
    WRITE    = 3'd3,
    ACK      = 3'd4
  } state_t;

  localparam int         ACC_DW   = 32;
  localparam int         LANES    = ACC_DW / 8;
  localparam int         CNT_W    = 4;
  localparam logic [3:0] SEL_FULL = 4'hF;
  localparam logic [3:0] SEL_NONE = 4'h0;

endpackage

// File: rtl/servant_byte_merge.sv
// Byte-lane merge: each lane takes new data where sel is set, old data otherwise.
// Purely combinational so it can sit on any read-modify-write path.
module servant_byte_merge
  import servant_acc_pkg::*;
(
  input  logic [ACC_DW-1:0] old_dat,
  input  logic [ACC_DW-1:0] new_dat,
  input  logic [LANES-1:0]  sel,
  output logic [ACC_DW-1:0] merged
);

  // per-lane select between old and new bytes
  always_comb begin
    merged = old_dat;
    for (int i = 0; i < LANES; i++) begin
      if (sel[i]) begin
        merged[8*i +: 8] = new_dat[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_dat[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/servant_acc_bridge.sv
// Wishbone classic responder for the matrix accelerator window.
// Reads wait a fixed latency; partial-lane writes become read-modify-write.
module servant_acc_bridge
  import servant_acc_pkg::*;
#(
  parameter int ADR_WIDTH    = 13,
  parameter int READ_LATENCY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [ADR_WIDTH-1:0] i_wb_adr,
  input  logic [ACC_DW-1:0]    i_wb_dat,
  input  logic [3:0]           i_wb_sel,
  input  logic                 i_wb_we,
  input  logic                 i_wb_cyc,
  output logic [ACC_DW-1:0]    o_wb_rdt,
  output logic                 o_wb_ack,
  output logic [ADR_WIDTH-1:0] o_acc_adr,
  output logic [ACC_DW-1:0]    o_acc_dat,
  output logic                 o_acc_we,
  input  logic [ACC_DW-1:0]    i_acc_rdt,
  output logic                 o_busy
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t                 state_r;
  state_t                 state_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [ACC_DW-1:0]      dat_r;
  logic [3:0]             sel_r;
  logic [ACC_DW-1:0]      merged_s;
  logic [ACC_DW-1:0]      wb_rdt_r;
  logic                   wb_ack_r;
  logic [ADR_WIDTH-1:0]   acc_adr_r;
  logic [ACC_DW-1:0]      acc_dat_r;
  logic                   acc_we_r;
  logic                   busy_r;
  logic                   cnt_done_s;

  assign cnt_done_s = (cnt_r == CNT_ZERO);

  servant_byte_merge u_merge (
    .old_dat (i_acc_rdt),
    .new_dat (dat_r),
    .sel     (sel_r),
    .merged  (merged_s)
  );

  // next-state decode; a dropped cyc only aborts while still waiting on the accelerator
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_wb_cyc) begin
          if (i_wb_we) begin
            if (i_wb_sel == SEL_FULL) begin
              state_s = WRITE;
            end else if (i_wb_sel == SEL_NONE) begin
              state_s = ACK;
            end else begin
              state_s = RMW_WAIT;
            end
          end else begin
            state_s = RD_WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD_WAIT: begin
        if (!i_wb_cyc) begin
          state_s = IDLE;
        end else if (cnt_done_s) begin
          state_s = ACK;
        end else begin
          state_s = RD_WAIT;
        end
      end
      RMW_WAIT: begin
        if (!i_wb_cyc) begin
          state_s = IDLE;
        end else if (cnt_done_s) begin
          state_s = WRITE;
        end else begin
          state_s = RMW_WAIT;
        end
      end
      WRITE:   state_s = ACK;
      ACK:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // state register and strobes, all registered from the next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= IDLE;
      wb_ack_r <= 1'b0;
      acc_we_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      wb_ack_r <= (state_s == ACK);
      acc_we_r <= (state_s == WRITE);
      busy_r   <= (state_s != IDLE);
    end
  end

  // request capture, latency counter and accelerator/wishbone data registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_r     <= CNT_ZERO;
      dat_r     <= {ACC_DW{1'b0}};
      sel_r     <= 4'h0;
      wb_rdt_r  <= {ACC_DW{1'b0}};
      acc_adr_r <= {ADR_WIDTH{1'b0}};
      acc_dat_r <= {ACC_DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (i_wb_cyc) begin
            acc_adr_r <= i_wb_adr;
            dat_r     <= i_wb_dat;
            sel_r     <= i_wb_sel;
            cnt_r     <= LAT_INIT;
            if (i_wb_we && (i_wb_sel == SEL_FULL)) begin
              acc_dat_r <= i_wb_dat;
            end
          end
        end
        RD_WAIT: begin
          if (!cnt_done_s) begin
            cnt_r <= cnt_r - 4'd1;
          end else if (i_wb_cyc) begin
            wb_rdt_r <= i_acc_rdt;
          end
        end
        RMW_WAIT: begin
          if (!cnt_done_s) begin
            cnt_r <= cnt_r - 4'd1;
          end else if (i_wb_cyc) begin
            acc_dat_r <= merged_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign o_wb_rdt  = wb_rdt_r;
  assign o_wb_ack  = wb_ack_r;
  assign o_acc_adr = acc_adr_r;
  assign o_acc_dat = acc_dat_r;
  assign o_acc_we  = acc_we_r;
  assign o_busy    = busy_r;

endmodule
